// File: rtl/prl_tx_scheduler.sv
// Protocol-layer transmit scheduler: arbitrates the shared PHY transmitter between
// SOP* messages and Hard/Cable Reset requests, reporting outcomes as sticky ALERT bits.
module prl_tx_scheduler #(
    parameter int CNT_W       = 10,
    parameter int CRC_TIMEOUT = 900,
    parameter int HR_TIMEOUT  = 900
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  iTRANSMIT,
    input  logic        iTRANSMIT_wr,
    input  logic        iPHY_tx_done,
    input  logic        iGoodCRC,
    input  logic [15:0] iALERT_clr,
    output logic        oPHY_tx_start,
    output logic [2:0]  oPHY_tx_type,
    output logic        oBusy,
    output logic [15:0] oALERT,
    output logic        oPHY_Stop_Attempting_Reset
);

    localparam logic [7:0] IDLE      = 8'b0000_0001;
    localparam logic [7:0] START     = 8'b0000_0010;
    localparam logic [7:0] WAIT_DONE = 8'b0000_0100;
    localparam logic [7:0] WAIT_CRC  = 8'b0000_1000;
    localparam logic [7:0] RETRY     = 8'b0001_0000;
    localparam logic [7:0] RST_START = 8'b0010_0000;
    localparam logic [7:0] RST_WAIT  = 8'b0100_0000;
    localparam logic [7:0] REPORT    = 8'b1000_0000;

    localparam logic [CNT_W-1:0] CRC_LIM = CNT_W'(CRC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HR_LIM  = CNT_W'(HR_TIMEOUT - 1);

    logic [7:0]       state;
    logic [2:0]       tx_type_q;
    logic [1:0]       retry_q;
    logic [1:0]       attempts;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_inc;
    logic             result_ok;
    logic [2:0]       wr_type;
    logic             wr_msg;
    logic             wr_rst;
    logic             in_msg;
    logic             preempt;
    logic             discard;
    logic [15:0]      set_bits;
    logic             unused_transmit_bits;

    assign wr_type   = iTRANSMIT[2:0];
    assign wr_msg    = iTRANSMIT_wr && (wr_type <= 3'd4);
    assign wr_rst    = iTRANSMIT_wr && ((wr_type == 3'd5) || (wr_type == 3'd6));
    assign in_msg    = |(state & (START | WAIT_DONE | WAIT_CRC | RETRY));
    assign preempt   = wr_rst && in_msg;
    assign discard   = preempt || (wr_msg && (state != IDLE));
    assign timer_inc = (timer == {CNT_W{1'b1}}) ? timer : timer + CNT_W'(1);
    assign oBusy     = (state != IDLE);

    assign unused_transmit_bits = &{1'b0, iTRANSMIT[7:6], iTRANSMIT[3]};

    // Bit 5 flags any refused or aborted message; bits 6/4 carry the final result.
    always_comb begin
        set_bits = 16'h0000;
        if (discard) begin
            set_bits[5] = 1'b1;
        end
        if (state == REPORT) begin
            set_bits[6] = result_ok;
            set_bits[4] = ~result_ok;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state                      <= IDLE;
            tx_type_q                  <= 3'd0;
            retry_q                    <= 2'd0;
            attempts                   <= 2'd0;
            timer                      <= '0;
            result_ok                  <= 1'b0;
            oPHY_tx_start              <= 1'b0;
            oPHY_tx_type               <= 3'd0;
            oALERT                     <= 16'h0000;
            oPHY_Stop_Attempting_Reset <= 1'b0;
        end else begin
            oALERT        <= (oALERT & ~iALERT_clr) | set_bits;
            oPHY_tx_start <= 1'b0;
            // A reset request aborts the message outright; late done/GoodCRC are dropped.
            if (preempt) begin
                state     <= RST_START;
                tx_type_q <= wr_type;
                attempts  <= 2'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (wr_msg) begin
                            tx_type_q <= wr_type;
                            retry_q   <= iTRANSMIT[5:4];
                            state     <= START;
                        end else if (wr_rst) begin
                            tx_type_q <= wr_type;
                            state     <= RST_START;
                        end
                    end
                    START: begin
                        oPHY_tx_start <= 1'b1;
                        oPHY_tx_type  <= tx_type_q;
                        state         <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        if (iPHY_tx_done) begin
                            timer <= '0;
                            state <= WAIT_CRC;
                        end
                    end
                    WAIT_CRC: begin
                        timer <= timer_inc;
                        if (iGoodCRC) begin
                            result_ok <= 1'b1;
                            state     <= REPORT;
                        end else if (timer >= CRC_LIM) begin
                            state <= RETRY;
                        end
                    end
                    RETRY: begin
                        if (attempts < retry_q) begin
                            attempts <= attempts + 2'd1;
                            state    <= START;
                        end else begin
                            result_ok <= 1'b0;
                            state     <= REPORT;
                        end
                    end
                    RST_START: begin
                        oPHY_tx_start <= 1'b1;
                        oPHY_tx_type  <= tx_type_q;
                        timer         <= '0;
                        state         <= RST_WAIT;
                    end
                    RST_WAIT: begin
                        timer <= timer_inc;
                        if (iPHY_tx_done) begin
                            result_ok <= 1'b1;
                            state     <= REPORT;
                        end else if (timer >= HR_LIM) begin
                            oPHY_Stop_Attempting_Reset <= 1'b1;
                            result_ok                  <= 1'b0;
                            state                      <= REPORT;
                        end
                    end
                    REPORT: begin
                        attempts <= 2'd0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/prl_tx_scheduler.md
Name: prl_tx_scheduler

Overview:
Protocol-layer transmit scheduler that sequences the single shared PHY transmitter between SOP* message transmissions, Hard Reset and Cable Reset requests. Requests arrive as TRANSMIT register writes. The block handles priority and pre-emption, GoodCRC wait with retries, and timeouts. It reports the outcome through TCPCI ALERT bits, with ALERT bits cleared by write-1-to-clear. It sits between the TCPC register file and the PHY transmit interface, alongside the reset-handling logic.

Parameters:
CNT_W, 10, width of the cycle timer
CRC_TIMEOUT, 900, cycles to wait for GoodCRC after PHY tx done (tReceive)
HR_TIMEOUT, 900, cycles allowed for a Hard/Cable Reset to complete (tHardResetComplete)

Ports:
CLK  in  1  clock
reset  in  1  asynchronous, active-high reset
iTRANSMIT  in  8  TRANSMIT register value; [2:0] type (0-4 SOP*, 5 Hard Reset, 6 Cable Reset, 7 reserved); [5:4] retry count
iTRANSMIT_wr  in  1  one-cycle write strobe for iTRANSMIT
iPHY_tx_done  in  1  one-cycle pulse: PHY finished sending current frame
iGoodCRC  in  1  one-cycle pulse: matching GoodCRC received
iALERT_clr  in  16  write-1-to-clear mask for oALERT, sampled every cycle
oPHY_tx_start  out  1  one-cycle pulse requesting PHY transmission
oPHY_tx_type  out  3  frame type for the PHY, held stable from start to done
oBusy  out  1  high in every state except IDLE
oALERT  out  16  sticky ALERT bits: [6] TransmitSuccessful, [5] TransmitDiscarded, [4] TransmitFailed
oPHY_Stop_Attempting_Reset  out  1  set when a reset times out; cleared only by reset

Behaviour:
- Reset (asynchronous): state=IDLE, all outputs 0, timer=0, retry counter=0, pending register empty.
- One-hot states: IDLE, START, WAIT_DONE, WAIT_CRC, RETRY, RST_START, RST_WAIT, REPORT.
- IDLE: on iTRANSMIT_wr, latch type and retry count.
  - type 5/6 -> RST_START.
  - type 0-4 -> START.
  - type 7 -> ignored, no alert.
- START: pulse oPHY_tx_start and drive oPHY_tx_type=latched type -> WAIT_DONE.
- WAIT_DONE: on iPHY_tx_done -> WAIT_CRC, timer cleared to 0.
- WAIT_CRC: timer increments each cycle.
  - iGoodCRC -> REPORT with result=success.
  - If timer reaches CRC_TIMEOUT-1 without GoodCRC -> RETRY.
  - A GoodCRC on the same cycle as the timeout wins (success).
- RETRY: if attempts_done < latched retry count, increment attempts_done -> START. Otherwise -> REPORT with result=failed.
  - Total attempts = retry count + 1.
  - Retry count 0 means a single attempt.
- RST_START: pulse oPHY_tx_start with type 5 or 6, clear timer -> RST_WAIT.
- RST_WAIT: timer increments each cycle.
  - iPHY_tx_done -> REPORT with result=success.
  - If timer reaches HR_TIMEOUT-1 first -> set oPHY_Stop_Attempting_Reset, REPORT with result=failed.
  - Done on the same cycle as the timeout counts as success.
- REPORT: set the ALERT bit in one cycle -> IDLE.
  - success sets bit 6; failed sets bit 4.
  - attempts_done cleared.
- Pre-emption: iTRANSMIT_wr with type 5/6 in any message state (START..RETRY) aborts the message.
  - Set bit 5 (Discarded) on the next edge -> RST_START.
  - Any in-flight done/GoodCRC for the aborted message is ignored.
- A write with type 0-4 while oBusy=1 is not queued: set bit 5, current operation unaffected.
- A write with type 5/6 while in RST_START/RST_WAIT/REPORT is ignored, with no alert.
- ALERT update each cycle: oALERT <= (oALERT & ~iALERT_clr) | set_bits. A set and clear of the same bit in the same cycle leaves the bit set.
- Timer saturates at 2^CNT_W-1. Timer comparisons are unsigned.
- oPHY_tx_type holds its value in IDLE, so the last type stays visible.
- oPHY_tx_start is never asserted on two consecutive cycles.
- Reset asserted mid-operation returns to the reset values immediately. No alert is produced for the aborted operation.
- Latency: write in IDLE -> oPHY_tx_start two edges later (latch edge, START edge).

Test Plan:
- Message with retry count 0: write 8'h00, pulse done, then GoodCRC 5 cycles later -> exactly one tx_start (type 0), oALERT=16'h0040, oBusy low after REPORT.
- GoodCRC never arrives: write 8'h21 (type 1, retries=2), pulse done on every attempt -> 3 tx_start pulses, each about CRC_TIMEOUT apart, then oALERT=16'h0010.
- Hard reset pre-empts a message: write 8'h00, then 8'h05 while in WAIT_CRC -> bit 5 set, next tx_start has type 5; done within 100 cycles -> bits 5 and 6 set, oPHY_Stop_Attempting_Reset=0.
- Cable reset timeout: write 8'h06 with no done -> after HR_TIMEOUT cycles, oPHY_Stop_Attempting_Reset=1 and oALERT[4]=1. A following iALERT_clr=16'h0010 clears bit 4 only.
- Busy discard and boundaries: write 8'h02 while busy -> bit 5 set with no extra tx_start. GoodCRC on the exact timeout cycle -> success (bit 6).
- Asynchronous reset asserted in WAIT_DONE between clock edges -> outputs zero immediately. After release, a new write 8'h00 sequences normally.
